// File: rtl/pipe_scoreboard_if.sv
// Decode-to-scoreboard bundle: issue request and operand fields in, stall/issue status out.
interface pipe_scoreboard_if #(
    parameter int unsigned REG_AW = 3,
    parameter int unsigned PERF_W = 16
);
    logic              issue_valid;
    logic [REG_AW-1:0] rs;
    logic              rs_valid;
    logic [REG_AW-1:0] rt;
    logic              rt_valid;
    logic [REG_AW-1:0] rd;
    logic              rd_valid;
    logic              is_load;
    logic              mem_busy;
    logic              perf_clr;
    logic              stall;
    logic              issue_fire;
    logic [1:0]        hazard_src;
    logic              any_pending;
    logic [PERF_W-1:0] stall_cycles;

    modport master (
        output issue_valid, rs, rs_valid, rt, rt_valid, rd, rd_valid,
               is_load, mem_busy, perf_clr,
        input  stall, issue_fire, hazard_src, any_pending, stall_cycles
    );

    modport slave (
        input  issue_valid, rs, rs_valid, rt, rt_valid, rd, rd_valid,
               is_load, mem_busy, perf_clr,
        output stall, issue_fire, hazard_src, any_pending, stall_cycles
    );
endinterface

// File: rtl/pipe_scoreboard.sv
// Per-register RAW scoreboard: counts cycles until a pending result is forwardable,
// stalls decode on hazards or memory-busy, and keeps a saturating stall counter.
module pipe_scoreboard #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned REG_AW   = 3,
    parameter int unsigned ALU_LAT  = 0,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned ZERO_REG = 0,
    parameter int unsigned PERF_W   = 16
) (
    input logic             clk,
    input logic             rst,
    pipe_scoreboard_if.slave sb
);
    localparam int unsigned MAX_LAT = (ALU_LAT > LOAD_LAT) ? ALU_LAT : LOAD_LAT;
    localparam int unsigned NUM_IDX = 1 << REG_AW;
    localparam logic [CNT_W-1:0] ALU_L  = CNT_W'(ALU_LAT);
    localparam logic [CNT_W-1:0] LOAD_L = CNT_W'(LOAD_LAT);

    if (MAX_LAT >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("pipe_scoreboard: CNT_W too narrow for max(ALU_LAT, LOAD_LAT)");
    end
    if (NUM_REGS > NUM_IDX) begin : g_reg_aw_check
        $error("pipe_scoreboard: REG_AW too narrow for NUM_REGS");
    end

    logic [CNT_W-1:0]   cnt [NUM_REGS];
    logic [NUM_IDX-1:0] pend;
    logic               haz_rs;
    logic               haz_rt;
    logic               stall_c;
    logic               fire_c;
    logic               wr_en;
    logic [CNT_W-1:0]   lat;
    logic [PERF_W-1:0]  stall_cnt;

    // Hazards look at state before this instruction's own write, so rs == rd never self-stalls.
    assign haz_rs  = sb.rs_valid && pend[sb.rs];
    assign haz_rt  = sb.rt_valid && pend[sb.rt];
    assign stall_c = sb.issue_valid && (haz_rs || haz_rt || sb.mem_busy);
    assign fire_c  = sb.issue_valid && !stall_c;
    assign wr_en   = fire_c && sb.rd_valid;
    assign lat     = sb.is_load ? LOAD_L : ALU_L;

    for (genvar i = 0; i < NUM_IDX; i++) begin : g_reg
        if (i < NUM_REGS) begin : g_live
            localparam bit HARD = (ZERO_REG != 0) && (i == 0);
            logic [CNT_W-1:0] dec;
            logic [CNT_W-1:0] nxt;

            // A frozen pipeline does not close the distance; max() keeps an older, longer writer.
            always_comb begin
                dec = cnt[i];
                if (!sb.mem_busy && cnt[i] != '0) dec = cnt[i] - CNT_W'(1);
                nxt = dec;
                if (!HARD && wr_en && sb.rd == REG_AW'(i) && lat > dec) nxt = lat;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) cnt[i] <= '0;
                else     cnt[i] <= nxt;
            end

            assign pend[i] = !HARD && (cnt[i] != '0);
        end else begin : g_pad
            assign pend[i] = 1'b0;
        end
    end

    // Saturating stall-cycle counter; clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          stall_cnt <= '0;
        else if (sb.perf_clr)             stall_cnt <= '0;
        else if (stall_c && !(&stall_cnt)) stall_cnt <= stall_cnt + PERF_W'(1);
    end

    assign sb.stall        = stall_c;
    assign sb.issue_fire   = fire_c;
    assign sb.hazard_src   = sb.issue_valid ? {haz_rt, haz_rs} : 2'b00;
    assign sb.any_pending  = |pend;
    assign sb.stall_cycles = stall_cnt;
endmodule
